// File: rtl/rto_buffer_core_if.sv
// Host write path and dispatch/error outputs of one real-time output channel.
// master = host/AXI side, slave = rto_buffer_core.
interface rto_buffer_core_if #(
  parameter int TS_WIDTH   = 64,
  parameter int DATA_WIDTH = 8
);
  localparam int EW = TS_WIDTH + DATA_WIDTH;

  logic                  write;
  logic [TS_WIDTH-1:0]   wr_ts;
  logic [DATA_WIDTH-1:0] wr_data;
  logic [EW-1:0]         rto_out;
  logic                  counter_matched;
  logic                  timestamp_error;
  logic                  overflow_error;
  logic                  order_error;
  logic [EW-1:0]         timestamp_error_data;
  logic [EW-1:0]         overflow_error_data;

  modport master (
    output write, wr_ts, wr_data,
    input  rto_out, counter_matched, timestamp_error, overflow_error, order_error,
    input  timestamp_error_data, overflow_error_data
  );

  modport slave (
    input  write, wr_ts, wr_data,
    output rto_out, counter_matched, timestamp_error, overflow_error, order_error,
    output timestamp_error_data, overflow_error_data
  );
endinterface

// File: rtl/rto_buffer_core.sv
// Timestamped event buffer: RAM -> read stage -> head stage, head dispatched when its ts equals counter.
// Accept-to-eligible latency 3 cycles; writes while full are dropped with overflow_error, no stall.
module rto_buffer_core #(
  parameter int TS_WIDTH   = 64,
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 10,
  parameter int THRESHOLD  = 1000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  auto_start,
  input  logic [TS_WIDTH-1:0]   counter,
  input  logic                  status_clear,
  rto_buffer_core_if.slave      io,
  output logic [2:0]            sticky_status,
  output logic [ADDR_WIDTH:0]   level,
  output logic                  full,
  output logic                  empty
);
  localparam int EW    = TS_WIDTH + DATA_WIDTH;
  localparam int LW    = ADDR_WIDTH + 1;
  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [EW-1:0]         mem [DEPTH];
  logic [EW-1:0]         ram_q;
  logic [EW-1:0]         head_dat;
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic                  s1_vld;
  logic                  head_vld;
  logic [TS_WIDTH-1:0]   last_ts;
  logic                  armed;

  logic [TS_WIDTH-1:0]   head_ts;
  logic                  hit, late, pop;
  logic                  accept, ovf_rej, ord_rej;
  logic                  head_load, rd_en, ram_has;

  always_comb begin
    head_ts   = head_dat[EW-1 -: TS_WIDTH];
    hit       = auto_start && head_vld && (head_ts == counter);
    late      = auto_start && head_vld && (counter > head_ts);
    pop       = hit || late;
    full      = (level >= LW'(THRESHOLD));
    empty     = (level == '0);
    ovf_rej   = io.write && !flush && full;
    ord_rej   = io.write && !flush && !full && !armed && (io.wr_ts <= last_ts);
    accept    = io.write && !flush && !full && (armed || (io.wr_ts > last_ts));
    // level counts RAM entries plus both pipeline stages
    ram_has   = (level != (LW'(s1_vld) + LW'(head_vld)));
    head_load = s1_vld && (!head_vld || pop);
    rd_en     = ram_has && (!s1_vld || head_load);
  end

  always_ff @(posedge clk) begin
    if (accept) mem[wr_ptr] <= {io.wr_ts, io.wr_data};
    if (rd_en)  ram_q <= mem[rd_ptr];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr                  <= '0;
      rd_ptr                  <= '0;
      s1_vld                  <= 1'b0;
      head_vld                <= 1'b0;
      head_dat                <= '0;
      level                   <= '0;
      last_ts                 <= '0;
      armed                   <= 1'b1;
      io.rto_out              <= '0;
      io.counter_matched      <= 1'b0;
      io.timestamp_error      <= 1'b0;
      io.overflow_error       <= 1'b0;
      io.order_error          <= 1'b0;
      io.timestamp_error_data <= '0;
      io.overflow_error_data  <= '0;
      sticky_status           <= '0;
    end else begin
      io.counter_matched <= hit;
      io.timestamp_error <= late;
      io.overflow_error  <= ovf_rej;
      io.order_error     <= ord_rej;
      if (hit)     io.rto_out              <= head_dat;
      if (late)    io.timestamp_error_data <= head_dat;
      if (ovf_rej) io.overflow_error_data  <= {io.wr_ts, io.wr_data};
      // set from the visible pulse so a clear in the pulse cycle loses
      sticky_status <= (sticky_status & ~{3{status_clear}})
                     | {io.order_error, io.overflow_error, io.timestamp_error};

      if (flush) begin
        wr_ptr   <= '0;
        rd_ptr   <= '0;
        s1_vld   <= 1'b0;
        head_vld <= 1'b0;
        level    <= '0;
        armed    <= 1'b1;
      end else begin
        if (accept) begin
          wr_ptr  <= wr_ptr + ADDR_WIDTH'(1);
          last_ts <= io.wr_ts;
          armed   <= 1'b0;
        end
        if (rd_en)     rd_ptr   <= rd_ptr + ADDR_WIDTH'(1);
        if (head_load) head_dat <= ram_q;
        head_vld <= head_load || (head_vld && !pop);
        s1_vld   <= rd_en || (s1_vld && !head_load);
        level    <= level + LW'(accept) - LW'(pop);
      end
    end
  end
endmodule

// File: tb/tb_rto_buffer_core.sv
// Bench for rto_buffer_core: directed scenarios plus randomized traffic against a queue-based model.
module tb_rto_buffer_core;
  localparam int TSW = 32;
  localparam int DW  = 8;
  localparam int AW  = 2;
  localparam int TH  = 4;
  localparam int EW  = TSW + DW;
  localparam int LW  = AW + 1;
  localparam int VW  = 3 * EW + 4 + 3 + LW + 2;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic           flush = 1'b0;
  logic           auto_start = 1'b0;
  logic [TSW-1:0] counter = '0;
  logic           status_clear = 1'b0;
  logic [2:0]     sticky_status;
  logic [LW-1:0]  level;
  logic           full, empty;

  rto_buffer_core_if #(.TS_WIDTH(TSW), .DATA_WIDTH(DW)) io ();

  rto_buffer_core #(.TS_WIDTH(TSW), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .THRESHOLD(TH)) dut (
    .clk(clk), .reset(reset), .flush(flush), .auto_start(auto_start),
    .counter(counter), .status_clear(status_clear), .io(io.slave),
    .sticky_status(sticky_status), .level(level), .full(full), .empty(empty)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: FIFO of accepted events, each eligible 3 cycles after its accept cycle.
  typedef struct { logic [TSW-1:0] ts; logic [DW-1:0] d; int acc; } ev_t;
  ev_t            q[$];
  int             cyc = 0;
  logic           m_armed = 1'b1;
  logic [TSW-1:0] m_last = '0;
  logic [EW-1:0]  e_rto = '0, e_tsd = '0, e_ovd = '0;
  logic           e_match = 1'b0, e_late = 1'b0, e_ovf = 1'b0, e_ord = 1'b0;
  logic [2:0]     e_sticky = '0;

  function automatic logic [VW-1:0] dut_vec();
    return {io.rto_out, io.counter_matched, io.timestamp_error, io.overflow_error, io.order_error,
            io.timestamp_error_data, io.overflow_error_data, sticky_status, level, full, empty};
  endfunction

  function automatic logic [VW-1:0] exp_vec();
    return {e_rto, e_match, e_late, e_ovf, e_ord, e_tsd, e_ovd, e_sticky,
            LW'(q.size()), q.size() >= TH, q.size() == 0};
  endfunction

  // Advance the model with the inputs currently driven, then clock the DUT once.
  task automatic cycle();
    logic hit, late, fulln, ovf, ord, acc;
    if (reset) begin
      q.delete(); m_armed = 1'b1; m_last = '0;
      e_rto = '0; e_tsd = '0; e_ovd = '0; e_sticky = '0;
      e_match = 1'b0; e_late = 1'b0; e_ovf = 1'b0; e_ord = 1'b0;
    end else begin
      hit = 1'b0; late = 1'b0;
      if (auto_start && q.size() > 0 && cyc >= q[0].acc + 3) begin
        if (q[0].ts == counter) hit = 1'b1;
        else if (counter > q[0].ts) late = 1'b1;
      end
      e_sticky = (e_sticky & ~{3{status_clear}}) | {e_ord, e_ovf, e_late};
      if (hit)  e_rto = {q[0].ts, q[0].d};
      if (late) e_tsd = {q[0].ts, q[0].d};
      fulln = (q.size() >= TH);
      ovf = io.write && !flush && fulln;
      ord = io.write && !flush && !fulln && !m_armed && (io.wr_ts <= m_last);
      acc = io.write && !flush && !fulln && !ord;
      if (ovf) e_ovd = {io.wr_ts, io.wr_data};
      e_match = hit; e_late = late; e_ovf = ovf; e_ord = ord;
      if (flush) begin
        q.delete(); m_armed = 1'b1;
      end else begin
        if (hit || late) void'(q.pop_front());
        if (acc) begin
          q.push_back('{ts: io.wr_ts, d: io.wr_data, acc: cyc});
          m_last = io.wr_ts; m_armed = 1'b0;
        end
      end
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic w, input logic [TSW-1:0] ts, input logic [DW-1:0] d);
    io.write = w; io.wr_ts = ts; io.wr_data = d;
  endtask

  task automatic do_reset();
    reset = 1'b1; flush = 1'b0; auto_start = 1'b0; status_clear = 1'b0;
    drive(1'b0, '0, '0);
    cycle();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (io.rto_out !== '0) begin errors++; $display("FAIL reset_rto got=%h want=0", io.rto_out); end
    checks++; if (io.counter_matched !== 1'b0) begin errors++; $display("FAIL reset_matched got=%b want=0", io.counter_matched); end
    checks++; if (sticky_status !== 3'b000) begin errors++; $display("FAIL reset_sticky got=%b want=000", sticky_status); end
    checks++; if (level !== '0) begin errors++; $display("FAIL reset_level got=%0d want=0", level); end
    checks++; if ({full, empty} !== 2'b01) begin errors++; $display("FAIL reset_full_empty got=%b want=01", {full, empty}); end
  endtask

  task automatic test_dispatch();
    int at[$];
    logic [EW-1:0] outs[$];
    do_reset();
    auto_start = 1'b1;
    for (int c = 90; c <= 106; c++) begin
      counter = TSW'(c);
      drive(c <= 92, TSW'(100 + c - 90), DW'(8'hA1 + c - 90));
      cycle();
      if (io.counter_matched) begin at.push_back(c + 1); outs.push_back(io.rto_out); end
    end
    drive(1'b0, '0, '0);
    checks++; if (at.size() != 3) begin errors++; $display("FAIL dispatch_count got=%0d want=3", at.size()); end
    for (int i = 0; i < at.size() && i < 3; i++) begin
      checks++;
      if (at[i] != 101 + i || outs[i] !== {TSW'(100 + i), DW'(8'hA1 + i)}) begin
        errors++;
        $display("FAIL dispatch_%0d got cnt=%0d out=%h want cnt=%0d out=%h", i, at[i], outs[i],
                 101 + i, {TSW'(100 + i), DW'(8'hA1 + i)});
      end
    end
  endtask

  task automatic test_overflow();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, TSW'(10 + i), DW'(i));
      cycle();
    end
    drive(1'b0, '0, '0);
    checks++; if (io.overflow_error !== 1'b1) begin errors++; $display("FAIL ovf_pulse got=%b want=1", io.overflow_error); end
    checks++; if (io.overflow_error_data !== {TSW'(14), DW'(4)}) begin errors++; $display("FAIL ovf_data got=%h want=%h", io.overflow_error_data, {TSW'(14), DW'(4)}); end
    checks++; if (level !== LW'(4) || full !== 1'b1) begin errors++; $display("FAIL ovf_level got=%0d/%b want=4/1", level, full); end
    cycle();
    checks++; if (sticky_status[1] !== 1'b1 || io.overflow_error !== 1'b0) begin errors++; $display("FAIL ovf_sticky got=%b/%b want=1/0", sticky_status[1], io.overflow_error); end
  endtask

  task automatic test_late();
    int found = -1, pulses = 0, matched = 0;
    do_reset();
    auto_start = 1'b1; counter = TSW'(60);
    drive(1'b1, TSW'(50), 8'h5A);
    cycle();
    drive(1'b0, '0, '0);
    for (int i = 1; i <= 8; i++) begin
      counter = TSW'(60 + i);
      cycle();
      if (io.timestamp_error) begin pulses++; if (found < 0) found = i; end
      if (io.counter_matched) matched++;
    end
    checks++; if (found != 3 || pulses != 1) begin errors++; $display("FAIL late_pulse got at=%0d n=%0d want at=3 n=1", found, pulses); end
    checks++; if (io.timestamp_error_data !== {TSW'(50), 8'h5A}) begin errors++; $display("FAIL late_data got=%h want=%h", io.timestamp_error_data, {TSW'(50), 8'h5A}); end
    checks++; if (matched != 0 || empty !== 1'b1) begin errors++; $display("FAIL late_empty got=%0d/%b want=0/1", matched, empty); end
  endtask

  task automatic test_order();
    int ord = 0;
    logic [TSW-1:0] seq[3];
    seq[0] = 20; seq[1] = 20; seq[2] = 19;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      drive(i < 3, (i < 3) ? seq[i] : '0, DW'(i));
      cycle();
      if (io.order_error) ord++;
    end
    checks++; if (ord != 2 || level !== LW'(1)) begin errors++; $display("FAIL order_count got=%0d/%0d want=2/1", ord, level); end
    flush = 1'b1; drive(1'b0, '0, '0);
    cycle();
    flush = 1'b0;
    checks++; if (level !== '0 || empty !== 1'b1) begin errors++; $display("FAIL order_flush got=%0d/%b want=0/1", level, empty); end
    drive(1'b1, TSW'(5), 8'h05);
    cycle();
    drive(1'b0, '0, '0);
    checks++; if (io.order_error !== 1'b0 || level !== LW'(1)) begin errors++; $display("FAIL order_rearm got=%b/%0d want=0/1", io.order_error, level); end
  endtask

  task automatic test_flush_reset();
    int seen = 0;
    do_reset();
    for (int i = 0; i < 3; i++) begin drive(1'b1, TSW'(30 + i), DW'(i)); cycle(); end
    checks++; if (level !== LW'(3)) begin errors++; $display("FAIL flush_pre got=%0d want=3", level); end
    flush = 1'b1; drive(1'b1, TSW'(40), 8'h40);
    cycle();
    flush = 1'b0; drive(1'b0, '0, '0);
    checks++; if (level !== '0 || empty !== 1'b1 || io.overflow_error !== 1'b0 || io.order_error !== 1'b0) begin
      errors++; $display("FAIL flush_write got lvl=%0d empty=%b ovf=%b ord=%b want 0/1/0/0", level, empty, io.overflow_error, io.order_error);
    end
    counter = TSW'(65);
    for (int i = 0; i < 3; i++) begin drive(1'b1, TSW'(70 + i), DW'(i)); cycle(); counter++; end
    drive(1'b0, '0, '0);
    auto_start = 1'b1;
    for (int i = 0; i < 20 && seen == 0; i++) begin
      cycle(); counter++;
      if (io.counter_matched) seen = 1;
    end
    checks++; if (seen == 0) begin errors++; $display("FAIL reset_mid_timeout got=no match want=match"); end
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    checks++; if (dut_vec() !== VW'(1)) begin errors++; $display("FAIL reset_mid got=%h want=%h", dut_vec(), VW'(1)); end
  endtask

  task automatic test_sticky();
    do_reset();
    drive(1'b1, TSW'(20), 8'h01); cycle();
    drive(1'b1, TSW'(20), 8'h02); cycle();
    drive(1'b0, '0, '0);
    checks++; if (io.order_error !== 1'b1) begin errors++; $display("FAIL sticky_pulse got=%b want=1", io.order_error); end
    status_clear = 1'b1;
    cycle();
    checks++; if (sticky_status[2] !== 1'b1) begin errors++; $display("FAIL sticky_set_wins got=%b want=1", sticky_status[2]); end
    cycle();
    status_clear = 1'b0;
    checks++; if (sticky_status !== 3'b000) begin errors++; $display("FAIL sticky_clear got=%b want=000", sticky_status); end
  endtask

  task automatic test_back_to_back();
    int at[$];
    logic [EW-1:0] outs[$];
    do_reset();
    for (int c = 190; c <= 210; c++) begin
      counter = TSW'(c);
      auto_start = (c >= 193);
      if (c <= 192)      drive(1'b1, TSW'(200 + c - 190), DW'(c));
      else if (c == 200) drive(1'b1, TSW'(203), 8'hCC);
      else               drive(1'b0, '0, '0);
      cycle();
      if (c == 200) begin
        checks++; if (level !== LW'(3)) begin errors++; $display("FAIL b2b_pop_push_level got=%0d want=3", level); end
      end
      if (io.counter_matched) begin at.push_back(c + 1); outs.push_back(io.rto_out); end
    end
    drive(1'b0, '0, '0);
    checks++; if (at.size() != 4) begin errors++; $display("FAIL b2b_count got=%0d want=4", at.size()); end
    for (int i = 0; i < at.size() && i < 4; i++) begin
      checks++;
      if (at[i] != 201 + i || outs[i][EW-1 -: TSW] !== TSW'(200 + i)) begin
        errors++; $display("FAIL b2b_%0d got cnt=%0d ts=%0d want cnt=%0d ts=%0d", i, at[i], outs[i][EW-1 -: TSW], 201 + i, 200 + i);
      end
    end
  endtask

  task automatic test_random();
    do_reset();
    counter = TSW'(1000);
    for (int n = 0; n < 4000; n++) begin
      reset        = ($urandom_range(0, 399) == 0);
      flush        = ($urandom_range(0, 39) == 0);
      status_clear = ($urandom_range(0, 11) == 0);
      auto_start   = ($urandom_range(0, 7) != 0);
      drive($urandom_range(0, 1) == 1, counter + TSW'($urandom_range(0, 12)) - TSW'(2), DW'($urandom));
      cycle();
      counter++;
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++; $display("FAIL random n=%0d got=%h want=%h", n, dut_vec(), exp_vec());
      end
    end
    reset = 1'b0; flush = 1'b0; status_clear = 1'b0;
    drive(1'b0, '0, '0);
  endtask

  initial begin
    drive(1'b0, '0, '0);
    test_reset();
    test_dispatch();
    test_overflow();
    test_late();
    test_order();
    test_flush_reset();
    test_sticky();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end
endmodule
